// File: rtl/progmem_arbiter_pkg.sv
// rtl/progmem_arbiter_pkg.sv - shared state encoding and response codes for the program memory arbiter
package progmem_arbiter_pkg;

  typedef logic [1:0] resp_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

endpackage

// File: rtl/progmem_arbiter.sv
// rtl/progmem_arbiter.sv - two-master program memory arbiter with slave wait timeout
// PROGMEM_ARB_ROUND_ROBIN_EN selects round-robin ties; otherwise master 1 always wins a tie.
module progmem_arbiter
  import progmem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic [DATA_W-1:0] m0_readdata,
  output logic [1:0]        m0_response,
  output logic              m0_waitrequest,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic [DATA_W-1:0] m1_readdata,
  output logic [1:0]        m1_response,
  output logic              m1_waitrequest,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_waitrequest
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]        state_q, state_d, cur_state;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              req0, req1, tie_to1;
  logic              g_read, g_write, g_cmd, expire;
  logic [ADDR_W-1:0] g_address;
  logic [DATA_W-1:0] g_writedata;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // While reset is held the outputs already look idle, so an interrupted transfer never completes.
  assign cur_state = rst_n ? state_q : ST_IDLE;

`ifdef PROGMEM_ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  assign tie_to1 = ~last_grant_q;

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == ST_IDLE && state_d == ST_GRANT0) last_grant_d = 1'b0;
    if (state_q == ST_IDLE && state_d == ST_GRANT1) last_grant_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end
`else
  assign tie_to1 = 1'b1;
`endif

  always_comb begin
    g_read      = 1'b0;
    g_write     = 1'b0;
    g_address   = '0;
    g_writedata = '0;
    case (cur_state)
      ST_GRANT0: begin
        g_read      = m0_read;
        g_write     = m0_write;
        g_address   = m0_address;
        g_writedata = m0_writedata;
      end
      ST_GRANT1: begin
        g_read      = m1_read;
        g_write     = m1_write;
        g_address   = m1_address;
        g_writedata = m1_writedata;
      end
      default: ;
    endcase
  end

  assign g_cmd       = g_read | g_write;
  assign expire      = g_cmd & (wait_cnt_q == CNT_W'(TIMEOUT_CYC));
  assign s_address   = g_address;
  assign s_writedata = g_writedata;
  assign s_write     = g_write;
  assign s_read      = g_read & ~g_write;
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

  always_comb begin
    m0_waitrequest = req0;
    m1_waitrequest = req1;
    m0_response    = RESP_OKAY;
    m1_response    = RESP_OKAY;
    if (cur_state == ST_GRANT0) begin
      m0_waitrequest = s_waitrequest & ~expire;
      if (expire) m0_response = RESP_SLVERR;
    end
    if (cur_state == ST_GRANT1) begin
      m1_waitrequest = s_waitrequest & ~expire;
      if (expire) m1_response = RESP_SLVERR;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        wait_cnt_d = '0;
        if (req0 && req1) state_d = tie_to1 ? ST_GRANT1 : ST_GRANT0;
        else if (req0)    state_d = ST_GRANT0;
        else if (req1)    state_d = ST_GRANT1;
      end
      ST_GRANT0, ST_GRANT1: begin
        // A dropped request, a timeout and a normal completion all end the grant.
        if (!g_cmd || expire || !s_waitrequest) state_d = ST_IDLE;
        else                                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_progmem_arbiter.sv
// tb/tb_progmem_arbiter.sv - scoreboard bench for progmem_arbiter with a behavioural program memory
module tb_progmem_arbiter;
  import progmem_arbiter_pkg::*;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int TIMEOUT_CYC = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] m0_address = '0, m1_address = '0;
  logic              m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [DATA_W-1:0] m0_writedata = '0, m1_writedata = '0;
  logic [DATA_W-1:0] m0_readdata, m1_readdata, s_writedata, s_readdata;
  logic [1:0]        m0_response, m1_response;
  logic              m0_waitrequest, m1_waitrequest, s_read, s_write, s_waitrequest;
  logic [ADDR_W-1:0] s_address;

  progmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_readdata(m0_readdata), .m0_response(m0_response), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_readdata(m1_readdata), .m1_response(m1_response), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
    .s_readdata(s_readdata), .s_waitrequest(s_waitrequest)
  );

  function automatic logic [DATA_W-1:0] pat(input int a);
    return 32'hC0DE_0000 ^ (32'(a) * 32'h0001_0003);
  endfunction

  // Program memory: stalls mem_wait cycles per command, or forever while mem_stuck.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  int mem_wait = 0;
  bit mem_stuck = 1'b0;
  int mem_cnt = 0, sw_cnt = 0, sr_cnt = 0;

  assign s_waitrequest = (s_read | s_write) && (mem_stuck || mem_cnt < mem_wait);
  assign s_readdata    = mem[s_address];

  always @(posedge clk) begin
    if ((s_read | s_write) && s_waitrequest) mem_cnt <= mem_cnt + 1;
    else                                     mem_cnt <= 0;
    if (s_write) sw_cnt <= sw_cnt + 1;
    if (s_read)  sr_cnt <= sr_cnt + 1;
    if (!rst_n) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= pat(i);
    end else if (s_write && !s_waitrequest) begin
      mem[s_address] <= s_writedata;
    end
  end

  typedef struct { bit rd; bit wr; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } op_t;
  typedef struct { int m; bit rd; logic [DATA_W-1:0] data; logic [1:0] resp; int cyc; } res_t;

  op_t  q0[$], q1[$];
  res_t sb[$], got[$];
  int   n_cmp = 0, n_bad = 0;

  task automatic apply_heads();
    if (q0.size() > 0) begin
      m0_read = q0[0].rd; m0_write = q0[0].wr; m0_address = q0[0].addr; m0_writedata = q0[0].data;
    end else begin
      m0_read = 1'b0; m0_write = 1'b0;
    end
    if (q1.size() > 0) begin
      m1_read = q1[0].rd; m1_write = q1[0].wr; m1_address = q1[0].addr; m1_writedata = q1[0].data;
    end else begin
      m1_read = 1'b0; m1_write = 1'b0;
    end
  endtask

  // Each master holds its head op until it completes, then presents its next op right away.
  task automatic run_masters(input int budget);
    int c = 0;
    bit d0, d1;
    got.delete();
    apply_heads();
    while ((q0.size() > 0 || q1.size() > 0) && c < budget) begin
      @(negedge clk);
      c++;
      d0 = (m0_read | m0_write) && !m0_waitrequest;
      d1 = (m1_read | m1_write) && !m1_waitrequest;
      if (d0) got.push_back('{0, 1'b0, m0_readdata, m0_response, c});
      if (d1) got.push_back('{1, 1'b0, m1_readdata, m1_response, c});
      @(posedge clk);
      #1;
      if (d0) void'(q0.pop_front());
      if (d1) void'(q1.pop_front());
      apply_heads();
    end
    if (q0.size() > 0 || q1.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL run_timeout: %0d/%0d ops still pending after %0d cycles, need 0", q0.size(), q1.size(), budget);
      q0.delete(); q1.delete();
      apply_heads();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m0_read = 1'b1; m0_address = 12'h123; m0_writedata = 32'h1111_1111;
    m1_write = 1'b1; m1_address = 12'h0AA; m1_writedata = 32'h2222_2222;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({s_read, s_write} !== 2'b00 || s_address !== '0 || s_writedata !== '0) begin
      n_bad++; $display("FAIL reset_slave: rd %b wr %b addr %h wdata %h, need all 0", s_read, s_write, s_address, s_writedata);
    end
    n_cmp++;
    if (m0_response !== RESP_OKAY || m1_response !== RESP_OKAY || m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
      n_bad++; $display("FAIL reset_master: resp %b/%b wait %b/%b, need 00/00 1/1", m0_response, m1_response, m0_waitrequest, m1_waitrequest);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1; m0_read = 1'b0; m1_write = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({s_read, s_write} !== 2'b00 || s_address !== '0 || s_writedata !== '0 || m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b0) begin
      n_bad++; $display("FAIL after_reset: rd %b wr %b addr %h wait %b/%b, need 0", s_read, s_write, s_address, m0_waitrequest, m1_waitrequest);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_read();
    int          tm[4] = '{0, 1, 0, 1};
    logic [11:0] ta[4] = '{12'h010, 12'h7FF, 12'h000, 12'h155};
    int          tw[4] = '{2, 0, 3, 1};
    res_t e, r;
    for (int i = 0; i < 4; i++) begin
      mem_wait = tw[i];
      if (tm[i] == 0) q0.push_back('{1'b1, 1'b0, ta[i], '0});
      else            q1.push_back('{1'b1, 1'b0, ta[i], '0});
      sb.push_back('{tm[i], 1'b1, pat(int'(ta[i])), RESP_OKAY, 2 + tw[i]});
      run_masters(50);
      while (sb.size() > 0) begin
        e = sb.pop_front(); n_cmp++;
        if (got.size() == 0) begin
          n_bad++; $display("FAIL read_%0d: no completion, need m%0d data %h", i, e.m, e.data);
        end else begin
          r = got.pop_front();
          if (r.m != e.m || r.resp !== e.resp || r.data !== e.data || r.cyc != e.cyc) begin
            n_bad++; $display("FAIL read_%0d: got m%0d data %h resp %b cyc %0d, need m%0d data %h resp %b cyc %0d",
                              i, r.m, r.data, r.resp, r.cyc, e.m, e.data, e.resp, e.cyc);
          end
        end
      end
    end
  endtask

  task automatic test_write();
    int sw0;
    res_t e, r;
    mem_wait = 0;
    sw0 = sw_cnt;
    q1.push_back('{1'b0, 1'b1, 12'h3FF, 32'hDEAD_BEEF});
    sb.push_back('{1, 1'b0, '0, RESP_OKAY, 2});
    run_masters(50);
    while (sb.size() > 0) begin
      e = sb.pop_front(); n_cmp++;
      if (got.size() == 0) begin
        n_bad++; $display("FAIL write: no completion, need m%0d", e.m);
      end else begin
        r = got.pop_front();
        if (r.m != e.m || r.resp !== e.resp || r.cyc != e.cyc) begin
          n_bad++; $display("FAIL write: got m%0d resp %b cyc %0d, need m%0d resp %b cyc %0d", r.m, r.resp, r.cyc, e.m, e.resp, e.cyc);
        end
      end
    end
    n_cmp++;
    if (got.size() != 0) begin n_bad++; $display("FAIL write_extra: %0d extra completions, need 0", got.size()); end
    n_cmp++;
    if (sw_cnt - sw0 != 1) begin n_bad++; $display("FAIL write_pulse: s_write high %0d cycles, need 1", sw_cnt - sw0); end
    n_cmp++;
    if (mem[12'h3FF] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL write_mem: mem[3ff] %h, need deadbeef", mem[12'h3FF]); end
    n_cmp++;
    if (m0_waitrequest !== 1'b0 || m0_response !== RESP_OKAY) begin
      n_bad++; $display("FAIL write_m0: wait %b resp %b, need 0 00", m0_waitrequest, m0_response);
    end
  endtask

  task automatic test_rw_together();
    int sw0, sr0;
    res_t e, r;
    mem_wait = 1;
    sw0 = sw_cnt; sr0 = sr_cnt;
    q0.push_back('{1'b1, 1'b1, 12'h020, 32'h0BAD_F00D});
    sb.push_back('{0, 1'b0, '0, RESP_OKAY, 3});
    run_masters(50);
    while (sb.size() > 0) begin
      e = sb.pop_front(); n_cmp++;
      if (got.size() == 0) begin
        n_bad++; $display("FAIL rw_both: no completion, need m%0d", e.m);
      end else begin
        r = got.pop_front();
        if (r.m != e.m || r.resp !== e.resp || r.cyc != e.cyc) begin
          n_bad++; $display("FAIL rw_both: got m%0d resp %b cyc %0d, need m%0d resp %b cyc %0d", r.m, r.resp, r.cyc, e.m, e.resp, e.cyc);
        end
      end
    end
    n_cmp++;
    if (sr_cnt - sr0 != 0 || sw_cnt - sw0 != 2) begin
      n_bad++; $display("FAIL rw_pulses: s_read %0d s_write %0d cycles, need 0 and 2", sr_cnt - sr0, sw_cnt - sw0);
    end
    n_cmp++;
    if (mem[12'h020] !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL rw_mem: mem[020] %h, need 0badf00d", mem[12'h020]); end
  endtask

  task automatic test_timeout();
    res_t e, r;
    mem_stuck = 1'b1;
    q0.push_back('{1'b1, 1'b0, 12'h040, '0});
    sb.push_back('{0, 1'b0, '0, RESP_SLVERR, 2 + TIMEOUT_CYC});
    run_masters(60);
    mem_stuck = 1'b0;
    mem_wait = 1;
    // A normal read straight after proves the grant was released back to IDLE.
    q0.push_back('{1'b1, 1'b0, 12'h041, '0});
    sb.push_back('{0, 1'b1, pat(12'h041), RESP_OKAY, 3});
    begin
      res_t first[$];
      first = got;
      run_masters(50);
      got = {first, got};
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); n_cmp++;
      if (got.size() == 0) begin
        n_bad++; $display("FAIL timeout: no completion, need m%0d resp %b", e.m, e.resp);
      end else begin
        r = got.pop_front();
        if (r.m != e.m || r.resp !== e.resp || (e.rd && r.data !== e.data) || r.cyc != e.cyc) begin
          n_bad++; $display("FAIL timeout: got m%0d data %h resp %b cyc %0d, need m%0d data %h resp %b cyc %0d",
                            r.m, r.data, r.resp, r.cyc, e.m, e.data, e.resp, e.cyc);
        end
      end
    end
    n_cmp++;
    if (m0_response !== RESP_OKAY) begin n_bad++; $display("FAIL timeout_resp_idle: resp %b, need 00", m0_response); end
  endtask

  task automatic test_reset_mid();
    res_t e, r;
    mem_wait = 5;
    m1_read = 1'b1; m1_address = 12'h100;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (s_read !== 1'b1 || s_address !== 12'h100) begin
      n_bad++; $display("FAIL rst_mid_grant: s_read %b addr %h, need 1 100", s_read, s_address);
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (s_read !== 1'b0 || m1_waitrequest !== 1'b1 || m1_response !== RESP_OKAY) begin
      n_bad++; $display("FAIL rst_mid_hold: s_read %b wait %b resp %b, need 0 1 00", s_read, m1_waitrequest, m1_response);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (s_read !== 1'b0 || m1_waitrequest !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid_idle: s_read %b wait %b, need 0 1", s_read, m1_waitrequest);
    end
    @(posedge clk);
    #1;
    mem_wait = 0;
    // m1 drops inside its fresh grant, which must end without a response before m0 is served.
    q0.push_back('{1'b1, 1'b0, 12'h0F0, '0});
    sb.push_back('{0, 1'b1, pat(12'h0F0), RESP_OKAY, 3});
    run_masters(50);
    while (sb.size() > 0) begin
      e = sb.pop_front(); n_cmp++;
      if (got.size() == 0) begin
        n_bad++; $display("FAIL rst_mid_next: no completion, need m%0d", e.m);
      end else begin
        r = got.pop_front();
        if (r.m != e.m || r.resp !== e.resp || r.data !== e.data || r.cyc != e.cyc) begin
          n_bad++; $display("FAIL rst_mid_next: got m%0d data %h resp %b cyc %0d, need m%0d data %h resp %b cyc %0d",
                            r.m, r.data, r.resp, r.cyc, e.m, e.data, e.resp, e.cyc);
        end
      end
    end
    n_cmp++;
    if (got.size() != 0) begin n_bad++; $display("FAIL rst_mid_extra: %0d extra completions, need 0", got.size()); end
  endtask

  task automatic test_tie();
    res_t e, r;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_wait = 1;
    for (int round = 0; round < 2; round++) begin
      if (round == 0) begin
        q0.push_back('{1'b1, 1'b0, 12'h0A0, '0});
        q0.push_back('{1'b1, 1'b0, 12'h0A1, '0});
        q1.push_back('{1'b1, 1'b0, 12'h1B0, '0});
`ifdef PROGMEM_ARB_ROUND_ROBIN_EN
        sb.push_back('{0, 1'b1, pat(12'h0A0), RESP_OKAY, 0});
        sb.push_back('{1, 1'b1, pat(12'h1B0), RESP_OKAY, 0});
        sb.push_back('{0, 1'b1, pat(12'h0A1), RESP_OKAY, 0});
`else
        sb.push_back('{1, 1'b1, pat(12'h1B0), RESP_OKAY, 0});
        sb.push_back('{0, 1'b1, pat(12'h0A0), RESP_OKAY, 0});
        sb.push_back('{0, 1'b1, pat(12'h0A1), RESP_OKAY, 0});
`endif
      end else begin
        q0.push_back('{1'b1, 1'b0, 12'h0C0, '0});
        q1.push_back('{1'b1, 1'b0, 12'h1D0, '0});
        sb.push_back('{1, 1'b1, pat(12'h1D0), RESP_OKAY, 0});
        sb.push_back('{0, 1'b1, pat(12'h0C0), RESP_OKAY, 0});
      end
      run_masters(80);
      while (sb.size() > 0) begin
        e = sb.pop_front(); n_cmp++;
        if (got.size() == 0) begin
          n_bad++; $display("FAIL tie_%0d: no completion, need m%0d data %h", round, e.m, e.data);
        end else begin
          r = got.pop_front();
          if (r.m != e.m || r.resp !== e.resp || r.data !== e.data) begin
            n_bad++; $display("FAIL tie_%0d: got m%0d data %h resp %b, need m%0d data %h resp %b",
                              round, r.m, r.data, r.resp, e.m, e.data, e.resp);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_rw_together();
    test_timeout();
    test_reset_mid();
    test_tie();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/progmem_arbiter.md
PROGMEM_ARBITER -- requirements
Module: progmem_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_W, 12, word address width.
- DATA_W, 32, data width.
- TIMEOUT_CYC, 15, maximum slave wait cycles before a granted transfer is aborted.
REQ-002 Ports, one per line: name, direction, width, meaning. Each mN_ line exists once for N=0 and once for N=1.
- clk, in, 1, single system clock.
- rst_n, in, 1, synchronous active-low reset.
- mN_address, in, ADDR_W, master N word address.
- mN_read, in, 1, master N read request.
- mN_write, in, 1, master N write request.
- mN_writedata, in, DATA_W, master N write data.
- mN_readdata, out, DATA_W, read data to master N.
- mN_response, out, 2, 00 = OKAY, 10 = SLVERR (timeout).
- mN_waitrequest, out, 1, master N stall.
- s_address, out, ADDR_W, to program memory.
- s_read, out, 1, to program memory.
- s_write, out, 1, to program memory.
- s_writedata, out, DATA_W, to program memory.
- s_readdata, in, DATA_W, from program memory.
- s_waitrequest, in, 1, from program memory.

Function
REQ-003 The FSM SHALL have three states: IDLE, GRANT0 and GRANT1.
REQ-004 In IDLE, s_read and s_write SHALL be 0, and each mN_waitrequest SHALL equal mN_read|mN_write.
REQ-005 In IDLE with any request pending, the FSM SHALL move to a GRANT state on the next clock, giving 1 cycle of arbitration latency.
REQ-006 When both masters request in the same IDLE cycle, the grant SHALL follow the arbitration policy in REQ-015.
REQ-007 In GRANTn, s_address, s_read, s_write and s_writedata SHALL be driven combinationally from master n. The other master's waitrequest SHALL be held high while it requests.
REQ-008 The granted master's waitrequest SHALL equal s_waitrequest, except during a timeout (REQ-010).
REQ-009 A transfer SHALL complete on the first cycle in which the granted command is asserted and its waitrequest is low. The FSM SHALL return to IDLE on the next clock. Back-to-back grants without an IDLE cycle are not permitted.
REQ-010 In a GRANT state, a wait counter SHALL increment each cycle s_waitrequest=1 and clear on entry to GRANT. When it reaches TIMEOUT_CYC:
- the granted master's waitrequest SHALL be forced low for 1 cycle;
- its response SHALL be 10;
- the FSM SHALL return to IDLE.
REQ-011 If the granted master drops both read and write before completion, the FSM SHALL return to IDLE on the next clock and issue no response.
REQ-012 If read and write are asserted together, the request SHALL be treated as a write. s_read SHALL be 0 in that case.
REQ-013 mN_readdata SHALL equal s_readdata for both masters. The value is valid only in the completion cycle of a read.
REQ-014 mN_response SHALL be 00 in every cycle except a timeout completion cycle.

Reset
REQ-016 When rst_n=0 at a clk edge, the following SHALL occur on that edge:
- FSM goes to IDLE;
- wait counter clears to 0;
- last-grant register is set to 1, so master 0 wins first under round-robin.
REQ-017 During and after reset: s_read=0, s_write=0, s_address=0, s_writedata=0, mN_response=00.
REQ-018 Reset asserted mid-transfer SHALL abandon the transfer with no completion signalled.

Configuration
REQ-015 Arbitration policy SHALL be set by macro PROGMEM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin. The master not granted last wins a tie, and the last-grant register updates on every grant.
- Undefined: fixed priority. Master 1 (loader/debug) always wins a tie, and the last-grant register is unused.

Structure
REQ-019 A shared package SHALL hold:
- the FSM state encoding (IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2);
- response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
REQ-020 The block SHALL be a single module with no sub-modules. The wait counter width SHALL be $clog2(TIMEOUT_CYC+1).

Verification
REQ-021 Directed scenarios, one per line (stimulus -> required response):
- m0 reads addr 0x010 against a memory with 2-cycle wait -> m0_waitrequest low on cycle 4 after request, m0_readdata = mem[0x010], m0_response 00.
- m1 writes 0x DEADBEEF to 0x3FF -> s_write high exactly 1 cycle, memory holds 0xDEADBEEF, m0 unaffected.
- m0 and m1 read simultaneously with ROUND_ROBIN_EN -> m0 served first, then m1; on the next tie m1 is served first. Without the macro -> m1 is served first on both ties.
- s_waitrequest stuck high during an m0 read -> after 15 wait cycles m0_waitrequest low, m0_response 10, FSM in IDLE.
- rst_n low for 1 cycle during a GRANT1 read -> s_read 0 on the next cycle, FSM IDLE, a subsequent m0 read completes normally.
- m0 asserts read and write together to 0x020 -> only s_write pulses, write completes.
